sr04_echo_emulator: RTL and testbench



---
 rtl/sr04_echo_emulator.sv | 165 ++++++++++++++++
 tb/tb_sr04_echo_emulator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor stand-in. A trig pulse of at least TRIG_MIN_US
// is answered, after a fixed burst delay, with an echo pulse. The echo width is
// proportional to dist_cm. A trig pulse that is too short raises a one-cycle
// trig_err instead.
module sr04_echo_emulator #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [13:0] dist_cm,
  output logic        echo,
  output logic        busy,
  output logic        trig_err
);

  localparam int          CYC_PER_US   = CLK_FREQ / 1_000_000;
  localparam logic [31:0] TRIG_MIN_CYC = 32'(TRIG_MIN_US * CYC_PER_US);
  localparam logic [31:0] BURST_CYC    = 32'(BURST_US * CYC_PER_US);
  localparam logic [31:0] TO_CYC       = 32'(TIMEOUT_US * CYC_PER_US);
  localparam logic [31:0] HOLD_CYC     = 32'(HOLDOFF_US * CYC_PER_US);
  localparam logic [31:0] CYC_PER_CM   = 32'(US_PER_CM * CYC_PER_US);
  localparam logic [13:0] MAX_CM_W     = 14'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_cnt, w_cnt;
  logic        r_sync1, r_trig_s, r_trig_d;
  logic        r_echo, w_echo;
  logic        r_busy, w_busy;
  logic        r_trig_err, w_trig_err;
  logic [13:0] r_dist_lat;
  logic        w_latch;
  logic        w_rise;
  logic [31:0] w_echo_len;

  // Two-flop synchronizer for the asynchronous trig, plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_trig_s <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_sync1  <= trig;
      r_trig_s <= r_sync1;
      r_trig_d <= r_trig_s;
    end
  end

  assign w_rise = r_trig_s & ~r_trig_d;

  // Echo length from the latched distance; zero or beyond range gives the timeout width
  always_comb begin
    if ((r_dist_lat == 14'd0) || (r_dist_lat > MAX_CM_W)) begin
      w_echo_len = TO_CYC;
    end else begin
      w_echo_len = {18'd0, r_dist_lat} * CYC_PER_CM;
    end
  end

  // Next-state, counter and output decisions for the measurement sequence
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt + 32'd1;
    w_echo     = r_echo;
    w_busy     = r_busy;
    w_trig_err = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt  = '0;
        w_echo = 1'b0;
        w_busy = 1'b0;
        if (w_rise) begin
          w_state = S_TRIG_HI;
          w_cnt   = 32'd1;
        end
      end
      S_TRIG_HI: begin
        if (r_trig_s) begin
          // Only need to know the pulse reached the minimum, so stop counting there
          w_cnt = (r_cnt >= TRIG_MIN_CYC) ? r_cnt : r_cnt + 32'd1;
        end else if (r_cnt >= TRIG_MIN_CYC) begin
          w_state = S_BURST;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_latch = 1'b1;
        end else begin
          w_state    = S_IDLE;
          w_cnt      = '0;
          w_trig_err = 1'b1;
        end
      end
      S_BURST: begin
        if (r_cnt >= BURST_CYC - 32'd1) begin
          w_state = S_ECHO;
          w_cnt   = '0;
          w_echo  = 1'b1;
        end
      end
      S_ECHO: begin
        if (r_cnt >= w_echo_len - 32'd1) begin
          w_state = S_HOLDOFF;
          w_cnt   = '0;
          w_echo  = 1'b0;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt >= HOLD_CYC - 32'd1) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_echo  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State register, cycle counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_trig_err <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_echo     <= w_echo;
      r_busy     <= w_busy;
      r_trig_err <= w_trig_err;
    end
  end

  // Capture the distance once, when a valid trig is accepted; later changes are ignored
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_dist_lat <= dist_cm;
    end
  end

  assign echo     = r_echo;
  assign busy     = r_busy;
  assign trig_err = r_trig_err;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Bench for sr04_echo_emulator. The design runs at a scaled clock (2 cycles per us)
// with shortened range and timeout values, so that each echo is only a few thousand cycles long.
`timescale 1ns/1ps
module tb_sr04_echo_emulator;

  localparam int CLK_FREQ    = 2_000_000;
  localparam int TRIG_MIN_US = 10;
  localparam int BURST_US    = 20;
  localparam int US_PER_CM   = 58;
  localparam int MAX_CM      = 40;
  localparam int TIMEOUT_US  = 3000;
  localparam int HOLDOFF_US  = 10;

  localparam int CPU     = CLK_FREQ / 1_000_000;
  localparam int MIN_C   = TRIG_MIN_US * CPU;
  localparam int BURST_C = BURST_US * CPU;
  localparam int TO_C    = TIMEOUT_US * CPU;
  localparam int HOLD_C  = HOLDOFF_US * CPU;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [13:0] dist_cm = 14'd17;
  logic        echo, busy, trig_err;

  int total = 0;
  int bad   = 0;

  sr04_echo_emulator #(
    .CLK_FREQ   (CLK_FREQ),
    .TRIG_MIN_US(TRIG_MIN_US),
    .BURST_US   (BURST_US),
    .US_PER_CM  (US_PER_CM),
    .MAX_CM     (MAX_CM),
    .TIMEOUT_US (TIMEOUT_US),
    .HOLDOFF_US (HOLDOFF_US)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .dist_cm (dist_cm),
    .echo    (echo),
    .busy    (busy),
    .trig_err(trig_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1);
  end

  function automatic longint exp_len(input int d);
    if (d == 0 || d > MAX_CM) return longint'(TO_C);
    return longint'(d) * US_PER_CM * CPU;
  endfunction

  // Timeline model: a trig pulse is considered to end at cycle F. That cycle marks out the
  // busy, echo and error windows; outputs are then checked on every cycle.
  longint n = 0;
  longint hi_start = -1;
  longint busy_s = 0, busy_e = 0, echo_s = 0, echo_e = 0, err_c = -1;
  bit     rd1 = 1'b1, rd2 = 1'b1, td1 = 1'b0, td2 = 1'b0, prev_ts = 1'b0;
  bit     ts, e_exp, b_exp, t_exp;
  bit     armed = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      n++;
      ts = (rd1 || rd2) ? 1'b0 : td2;
      if (rd1) begin
        hi_start = -1; busy_s = 0; busy_e = 0; echo_s = 0; echo_e = 0; err_c = -1;
        armed = 1'b1;
      end else if (hi_start >= 0) begin
        if (!ts) begin
          if (n - hi_start >= MIN_C) begin
            busy_s = n + 1;
            echo_s = n + 1 + BURST_C;
            echo_e = echo_s + exp_len(int'(dist_cm));
            busy_e = echo_e + HOLD_C;
          end else begin
            err_c = n + 1;
          end
          hi_start = -1;
        end
      end else if (n >= busy_e && ts && !prev_ts) begin
        hi_start = n;
      end
      e_exp = (n >= echo_s) && (n < echo_e);
      b_exp = (n >= busy_s) && (n < busy_e);
      t_exp = (n == err_c);
      if (armed) begin
        total++;
        if (echo !== e_exp || busy !== b_exp || trig_err !== t_exp) begin
          bad++;
          $display("FAIL cycle %0d echo/busy/trig_err: got %b%b%b want %b%b%b",
                   n, echo, busy, trig_err, e_exp, b_exp, t_exp);
        end
      end
      prev_ts = ts;
      rd2 = rd1; rd1 = rst;
      td2 = td1; td1 = trig;
    end
  end

  // Running tallies of echo-high cycles, echo rises and trig_err pulses
  int  echo_hi = 0, rises = 0, errs = 0;
  bit  prev_echo = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        if (echo === 1'b1) echo_hi++;
        if (echo === 1'b1 && !prev_echo) rises++;
        if (trig_err === 1'b1) errs++;
        prev_echo = (echo === 1'b1);
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic pulse(input int w);
    @(posedge clk); #1 trig = 1'b1;
    repeat (w) @(posedge clk);
    #1 trig = 1'b0;
  endtask

  // Called just after trig is lowered. It measures: the cycles until echo rises;
  // the echo width; and the busy cycles left after echo falls.
  task automatic measure(input string nm, input int w_exp);
    int rise, width, tail;
    rise = -1; width = 0; tail = -1;
    for (int k = 1; k <= 20000; k++) begin
      @(posedge clk); #1;
      if (echo) begin rise = k; break; end
    end
    if (rise > 0) begin
      width = 1;
      for (int k = 0; k < 20000; k++) begin
        @(posedge clk); #1;
        if (!echo) break;
        width++;
      end
      tail = 0;
      for (int k = 0; k < 2000; k++) begin
        if (!busy) break;
        tail++;
        @(posedge clk); #1;
      end
    end
    chk({nm, " echo rise delay"}, rise, 43);   // 2 sync + 1 + 40 burst cycles
    chk({nm, " echo width"}, width, w_exp);
    chk({nm, " busy after echo"}, tail, 20);
  endtask

  task automatic err_case(input string nm, input int w);
    int e0, h0, bc;
    e0 = errs; h0 = echo_hi; bc = 0;
    pulse(w);
    repeat (100) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    chk({nm, " trig_err pulses"}, errs - e0, 1);
    chk({nm, " echo cycles"}, echo_hi - h0, 0);
    chk({nm, " busy cycles"}, bc, 0);
  endtask

  task automatic wait_echo(input string nm);
    int got;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (echo) begin got = 1; break; end
    end
    chk({nm, " echo started"}, got, 1);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk({nm, " returned idle"}, busy, 0);
  endtask

  initial begin
    int e0, r0, x0, bc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset echo", echo, 0);
    chk("reset busy", busy, 0);
    chk("reset trig_err", trig_err, 0);
    repeat (5) @(posedge clk);

    // Nominal measurement at 17 cm
    dist_cm = 14'd17;
    x0 = errs;
    pulse(20);
    measure("17cm", 1972);
    chk("17cm trig_err pulses", errs - x0, 0);

    // Short trig pulses, then the exact minimum
    err_case("trig 10", 10);
    err_case("trig 19", 19);
    pulse(20);
    measure("trig 20", 1972);

    // Out-of-range and boundary distances
    dist_cm = 14'd0;
    pulse(20);
    measure("0cm", 6000);
    dist_cm = 14'd41;
    pulse(20);
    measure("41cm", 6000);
    dist_cm = 14'd40;
    pulse(20);
    measure("40cm", 4640);
    dist_cm = 14'd1;
    pulse(20);
    measure("1cm", 116);

    // Trig and distance disturbance during an echo
    dist_cm = 14'd17;
    e0 = echo_hi; r0 = rises; x0 = errs;
    pulse(20);
    wait_echo("disturb");
    repeat (200) @(posedge clk);
    #1 trig = 1'b1; dist_cm = 14'd100;
    repeat (20) @(posedge clk);
    #1 trig = 1'b0;
    wait_idle("disturb");
    chk("disturb echo cycles", echo_hi - e0, 1972);
    chk("disturb echo rises", rises - r0, 1);
    chk("disturb trig_err pulses", errs - x0, 0);

    // Trig held high: no echo until it is released
    dist_cm = 14'd5;
    e0 = echo_hi; bc = 0;
    @(posedge clk); #1 trig = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    chk("held trig echo cycles", echo_hi - e0, 0);
    chk("held trig busy cycles", bc, 0);
    trig = 1'b0;
    measure("held release 5cm", 580);

    // Reset in the middle of an echo
    dist_cm = 14'd17;
    pulse(20);
    wait_echo("mid reset");
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset echo", echo, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset trig_err", trig_err, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    dist_cm = 14'd5;
    pulse(20);
    measure("post reset 5cm", 580);

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
